instr_fetch_unit: RTL and testbench

//   Front end of the MIPS core: owns the PC, fetches 32-bit instructions from instruction memory

---
 rtl/mips_pkg.sv | 36 +++
 rtl/fetch_pc_gen.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end: fetch FSM states,
// instruction field positions, primary opcodes and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Word-aligned branch displacement: sign-extended imm shifted left by two.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter for the fetch unit: holds pc, forms pc+4 and the branch
// target, and advances to the selected next PC when the current instruction retires.
module fetch_pc_gen
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        branch_take,
  input  logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] plus4;
  logic [31:0] branch_target;

  always_comb begin
    plus4         = pc_q + 32'd4;
    branch_target = plus4 + branch_offset(imm);
    pc_d          = pc_q;
    if (load_en) begin
      pc_d = branch_take ? branch_target : plus4;
    end
  end

  // Low bits are forced to zero so a misaligned RESET_PC can never leak out.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch front end: single-outstanding request/response fetch
// FSM, registered instruction with decoded field slices, and a sticky error flag.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_take,
  output logic        err_rsp
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  instr_q;
  logic [31:0]  instr_d;
  logic         err_q;
  logic         err_d;
  logic         req_fire;
  logic         pc_load;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      // NOTE: instr is a visible output, so it is reset; pure data storage elsewhere need not be.
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    unique case (state_q)
      FETCH: if (req_fire) state_d = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = HOLD;
        end
      end
      HOLD:    if (instr_ready) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // A response is only legal while waiting; one arriving with the accept is early.
  always_comb begin
    imem_req_valid = (state_q == FETCH) && !reset;
    instr_valid    = (state_q == HOLD);
    err_d          = err_q | (imem_rsp_valid && (state_q != WAIT));
  end

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pc_load  = instr_valid && instr_ready;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .reset       (reset),
    .load_en     (pc_load),
    .branch_take (branch_take),
    .imm         (instr_q[IMM_HI:IMM_LO]),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  assign imem_addr = pc;
  assign instr     = instr_q;
  assign opcode    = instr_q[OPC_HI:OPC_LO];
  assign funct     = instr_q[FUNCT_HI:FUNCT_LO];
  assign rs        = instr_q[RS_HI:RS_LO];
  assign rt        = instr_q[RT_HI:RT_LO];
  assign rd        = instr_q[RD_HI:RD_LO];
  assign imm       = instr_q[IMM_HI:IMM_LO];
  assign err_rsp   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// run in lockstep from shared stimulus; expected instr/pc pushed on response, popped on instr_valid.
module tb_instr_fetch_unit;

  localparam logic [31:0] HI_RESET = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_ready = 1'b0;
  logic        branch_take = 1'b0;

  logic        imem_req_valid, instr_valid, err_rsp;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  logic        h_req_valid, h_instr_valid, h_err;
  logic [31:0] h_addr, h_instr, h_pc, h_pc_plus4;
  logic [5:0]  h_opcode, h_funct;
  logic [4:0]  h_rs, h_rt, h_rd;
  logic [15:0] h_imm;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .pc(pc), .pc_plus4(pc_plus4), .branch_take(branch_take), .err_rsp(err_rsp)
  );

  instr_fetch_unit #(.RESET_PC(HI_RESET)) dut_hi (
    .clk(clk), .reset(reset),
    .imem_req_valid(h_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(h_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(h_instr_valid), .instr_ready(instr_ready), .instr(h_instr),
    .opcode(h_opcode), .funct(h_funct), .rs(h_rs), .rt(h_rt), .rd(h_rd), .imm(h_imm),
    .pc(h_pc), .pc_plus4(h_pc_plus4), .branch_take(branch_take), .err_rsp(h_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_hi;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_pc_hi = HI_RESET;

  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [31:0] word,
                                                input bit take);
    logic [31:0] off;
    off = {{14{word[15]}}, word[15:0], 2'b00};
    return take ? (cur + 32'd4 + off) : (cur + 32'd4);
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0; branch_take = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_pc = '0;
    exp_pc_hi = HI_RESET;
    sb.delete();
  endtask

  // Drives one full fetch: optional request back-pressure, response, optional consumer stall
  // (with a stray branch_take and optionally a stray response), then retirement.
  task automatic do_fetch(input logic [31:0] data, input bit take, input int ready_stall,
                          input int hold_stall, input bit spur, output int accept_cyc);
    int   t;
    exp_t e;
    t = 0;
    while (imem_req_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_checks++;
    if (imem_req_valid !== 1'b1) $display("FAIL req_timeout: req_valid=%b want 1", imem_req_valid);
    else n_pass++;
    n_checks++;
    if (imem_addr !== exp_pc) $display("FAIL req_addr: got %h want %h", imem_addr, exp_pc);
    else n_pass++;
    n_checks++;
    if (h_addr !== exp_pc_hi) $display("FAIL req_addr_hi: got %h want %h", h_addr, exp_pc_hi);
    else n_pass++;
    for (int i = 0; i < ready_stall; i++) begin
      imem_req_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc)
        $display("FAIL req_hold: valid=%b addr=%h want 1 %h", imem_req_valid, imem_addr, exp_pc);
      else n_pass++;
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    n_checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL wait_state: req_valid=%b instr_valid=%b want 0 0", imem_req_valid, instr_valid);
    else n_pass++;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    e.instr = data; e.pc = exp_pc; e.pc_hi = exp_pc_hi;
    sb.push_back(e);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = ~data;
    for (int i = 0; i < hold_stall; i++) begin
      instr_ready = 1'b0;
      branch_take = 1'b1;
      if (spur && i == 0) imem_rsp_valid = 1'b1;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== data || pc !== exp_pc || imem_req_valid !== 1'b0)
        $display("FAIL hold_stable: valid=%b instr=%h pc=%h req=%b want 1 %h %h 0",
                 instr_valid, instr, pc, imem_req_valid, data, exp_pc);
      else n_pass++;
    end
    branch_take = 1'b0;
    t = 0;
    while (instr_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_checks++;
    if (instr_valid !== 1'b1 || sb.size() == 0)
      $display("FAIL instr_timeout: instr_valid=%b queued=%0d want 1 >0", instr_valid, sb.size());
    else n_pass++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (instr !== e.instr || pc !== e.pc || pc_plus4 !== e.pc + 32'd4)
        $display("FAIL sb_instr: instr=%h pc=%h pc4=%h want %h %h %h",
                 instr, pc, pc_plus4, e.instr, e.pc, e.pc + 32'd4);
      else n_pass++;
      n_checks++;
      if (opcode !== e.instr[31:26] || rs !== e.instr[25:21] || rt !== e.instr[20:16] ||
          rd !== e.instr[15:11] || funct !== e.instr[5:0] || imm !== e.instr[15:0])
        $display("FAIL sb_fields: op=%h rs=%0d rt=%0d rd=%0d fn=%h imm=%h for %h",
                 opcode, rs, rt, rd, funct, imm, e.instr);
      else n_pass++;
      n_checks++;
      if (h_pc !== e.pc_hi || h_pc_plus4 !== e.pc_hi + 32'd4)
        $display("FAIL sb_pc_hi: pc=%h pc4=%h want %h %h", h_pc, h_pc_plus4, e.pc_hi,
                 e.pc_hi + 32'd4);
      else n_pass++;
    end
    accept_cyc  = cyc;
    instr_ready = 1'b1;
    branch_take = take;
    @(negedge clk);
    instr_ready = 1'b0;
    branch_take = 1'b0;
    exp_pc    = model_next_pc(exp_pc, data, take);
    exp_pc_hi = model_next_pc(exp_pc_hi, data, take);
  endtask

  task automatic test_reset();
    int rel;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || err_rsp !== 1'b0)
      $display("FAIL reset_ctrl: req=%b iv=%b err=%b want 0 0 0", imem_req_valid, instr_valid, err_rsp);
    else n_pass++;
    n_checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || h_pc !== HI_RESET)
      $display("FAIL reset_regs: pc=%h instr=%h pc_hi=%h want 0 0 %h", pc, instr, h_pc, HI_RESET);
    else n_pass++;
    reset = 1'b0;
    imem_req_ready = 1'b1;
    rel = cyc;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL first_req: valid=%b addr=%h want 1 0", imem_req_valid, imem_addr);
    else n_pass++;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h8C22_0004;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || cyc - rel != 2)
      $display("FAIL first_latency: instr_valid=%b edges=%0d want 1 2", instr_valid, cyc - rel);
    else n_pass++;
    n_checks++;
    if (opcode !== 6'h23 || rs !== 5'd1 || rt !== 5'd2 || imm !== 16'h0004 || pc !== 32'h0)
      $display("FAIL first_fields: op=%h rs=%0d rt=%0d imm=%h pc=%h want 23 1 2 0004 0",
               opcode, rs, rt, imm, pc);
    else n_pass++;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic test_straight_line();
    int acc[4];
    logic [31:0] words[4];
    words[0] = 32'h0022_1820; words[1] = 32'hAC43_0008;
    words[2] = 32'h8C64_FFF0; words[3] = 32'h00A6_3822;
    apply_reset();
    for (int i = 0; i < 4; i++) do_fetch(words[i], 1'b0, 0, 0, 1'b0, acc[i]);
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] != 3)
        $display("FAIL issue_rate: gap=%0d cycles want 3", acc[i] - acc[i-1]);
      else n_pass++;
    end
    n_checks++;
    if (imem_addr !== 32'h10) $display("FAIL straight_end: addr=%h want 00000010", imem_addr);
    else n_pass++;
  endtask

  task automatic test_branch();
    int acc;
    apply_reset();
    do_fetch(32'h0022_1820, 1'b0, 0, 0, 1'b0, acc);
    do_fetch(32'h0022_1820, 1'b0, 0, 0, 1'b0, acc);
    do_fetch(32'h1000_FFFE, 1'b1, 0, 0, 1'b0, acc);
    n_checks++;
    if (imem_addr !== 32'h4) $display("FAIL beq_taken: addr=%h want 00000004", imem_addr);
    else n_pass++;
    do_fetch(32'h0022_1820, 1'b0, 0, 0, 1'b0, acc);
    do_fetch(32'h1000_FFFE, 1'b0, 0, 0, 1'b0, acc);
    n_checks++;
    if (imem_addr !== 32'hC) $display("FAIL beq_not_taken: addr=%h want 0000000c", imem_addr);
    else n_pass++;
  endtask

  task automatic test_stalls();
    int acc;
    do_fetch(32'h8C22_0004, 1'b0, 5, 4, 1'b0, acc);
    n_checks++;
    if (imem_addr !== 32'h10 || err_rsp !== 1'b0)
      $display("FAIL stall_end: addr=%h err=%b want 00000010 0", imem_addr, err_rsp);
    else n_pass++;
  endtask

  task automatic test_err_rsp();
    int acc;
    do_fetch(32'hAC43_0008, 1'b0, 0, 2, 1'b1, acc);
    n_checks++;
    if (err_rsp !== 1'b1 || h_err !== 1'b1)
      $display("FAIL err_set: err=%b err_hi=%b want 1 1", err_rsp, h_err);
    else n_pass++;
    do_fetch(32'h0022_1820, 1'b0, 0, 0, 1'b0, acc);
    n_checks++;
    if (err_rsp !== 1'b1) $display("FAIL err_sticky: err=%b want 1", err_rsp);
    else n_pass++;
  endtask

  task automatic test_reset_midway();
    int acc;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pc !== 32'h0 || h_pc !== HI_RESET || imem_req_valid !== 1'b0 || err_rsp !== 1'b0)
      $display("FAIL reset_in_wait: pc=%h pc_hi=%h req=%b err=%b want 0 %h 0 0",
               pc, h_pc, imem_req_valid, err_rsp, HI_RESET);
    else n_pass++;
    reset = 1'b0;
    exp_pc = '0; exp_pc_hi = HI_RESET;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0)
      $display("FAIL reset_in_hold: iv=%b instr=%h pc=%h want 0 0 0", instr_valid, instr, pc);
    else n_pass++;
    reset = 1'b0;
    do_fetch(32'h0022_1820, 1'b0, 0, 0, 1'b0, acc);
    n_checks++;
    if (h_addr !== 32'h0) $display("FAIL wrap_hi: addr=%h want 00000000", h_addr);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_straight_line();
    test_branch();
    test_stalls();
    test_err_rsp();
    test_reset_midway();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
